// File: rtl/lsu_riscv.sv
// lsu_riscv: load-store unit between the core decoder and data memory.
//
// Takes one load/store request, issues one word-aligned memory access, steers
// byte enables and store lanes, extends load data, and holds the core stalled
// until the access finishes. Misaligned or illegal-size requests and
// memory-ack timeouts end with a one-cycle error in DONE.
//
// Ports
//   clk_i            clock, rising edge
//   arstn_i          asynchronous active-low reset
//   lsu_req_i        core request, held while stalled
//   lsu_we_i         1=store, 0=load
//   lsu_size_i       funct3: 0=B 1=H 2=W 4=BU 5=HU
//   lsu_addr_i       byte address
//   lsu_data_i       store data
//   lsu_data_o       extended load data, valid in DONE
//   lsu_stall_req_o  stall core pipeline
//   lsu_err_o        access error, valid in DONE
//   data_req_o       memory request, high while BUSY
//   data_we_o        memory write enable
//   data_be_o        byte enables
//   data_addr_o      word-aligned address
//   data_wdata_o     lane-replicated store data
//   data_rdata_i     memory read word, valid with data_ack_i
//   data_ack_i       memory completion pulse
//
// state | meaning
// IDLE  | waiting for lsu_req_i; decode and legality check
// BUSY  | memory request outstanding, counting toward timeout
// DONE  | one-cycle completion: stall released, err/load data presented

module lsu_riscv #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_ack_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    size_q, size_d;
  logic [1:0]    off_q, off_d;

  logic          illegal;
  logic [3:0]    be_new;
  logic [31:0]   wdata_new;

  function automatic logic [31:0] extend(input logic [2:0]  sz,
                                         input logic [1:0]  off,
                                         input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{off, 3'b000} +: 8];
    h = rd[{off[1], 4'b0000} +: 16];
    case (sz)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  always_comb begin
    illegal = 1'b0;
    case (lsu_size_i)
      3'd0:    illegal = 1'b0;
      3'd1:    illegal = lsu_addr_i[0];
      3'd2:    illegal = |lsu_addr_i[1:0];
      3'd4:    illegal = lsu_we_i;
      3'd5:    illegal = lsu_we_i | lsu_addr_i[0];
      default: illegal = 1'b1;
    endcase
  end

  // BU/HU share the B/H lane layout, so only size[1:0] matters here.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = lsu_data_i;
    case (lsu_size_i[1:0])
      2'd0: begin
        be_new    = 4'b0001 << lsu_addr_i[1:0];
        wdata_new = {4{lsu_data_i[7:0]}};
      end
      2'd1: begin
        be_new    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        wdata_new = {2{lsu_data_i[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = lsu_data_i;
      end
    endcase
  end

  // err and load data default to zero so they are only ever non-zero in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    rdata_d = '0;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    off_d   = off_q;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          if (illegal) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            we_d    = lsu_we_i;
            be_d    = be_new;
            addr_d  = {lsu_addr_i[31:2], 2'b00};
            wdata_d = wdata_new;
            size_d  = lsu_size_i;
            off_d   = lsu_addr_i[1:0];
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (data_ack_i) begin
          rdata_d = we_q ? 32'd0 : extend(size_q, off_q, data_rdata_i);
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      off_q   <= off_d;
    end
  end

  assign lsu_stall_req_o = lsu_req_i & (state_q != DONE);
  assign lsu_err_o       = err_q;
  assign lsu_data_o      = rdata_q;
  assign data_req_o      = (state_q == BUSY);
  assign data_we_o       = we_q;
  assign data_be_o       = be_q;
  assign data_addr_o     = addr_q;
  assign data_wdata_o    = wdata_q;

endmodule

// File: tb/tb_lsu_riscv.sv
module tb_lsu_riscv;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [2:0]  lsu_size_i = '0;
  logic [31:0] lsu_addr_i = '0;
  logic [31:0] lsu_data_i = '0;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o;
  logic        lsu_err_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i = '0;
  logic        data_ack_i = 1'b0;

  int errors = 0;
  int checks = 0;

  int          stall_n, req_n;
  logic        err_s, we_s, done_s;
  logic [31:0] dout_s, addr_s, wdata_s;
  logic [3:0]  be_s;

  always #5 clk_i = ~clk_i;

  lsu_riscv #(.MAX_WAIT(4)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .lsu_data_o(lsu_data_o), .lsu_stall_req_o(lsu_stall_req_o),
    .lsu_err_o(lsu_err_o), .data_req_o(data_req_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_addr_o(data_addr_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
    .data_ack_i(data_ack_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one request; ack_at = BUSY cycle (1-based) carrying the ack, 0 = never.
  // Entered and left at posedge+1.
  task automatic do_access(input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rd);
    lsu_req_i  = 1'b1;
    lsu_we_i   = we;
    lsu_size_i = size;
    lsu_addr_i = addr;
    lsu_data_i = wd;
    stall_n = 0; req_n = 0; done_s = 1'b0; err_s = 1'b0; dout_s = '0;
    be_s = '0; addr_s = '0; wdata_s = '0; we_s = 1'b0;
    for (int c = 0; c < 40 && !done_s; c++) begin
      #1;
      if (lsu_stall_req_o) stall_n++;
      if (data_req_o) begin
        req_n++;
        be_s = data_be_o; addr_s = data_addr_o; wdata_s = data_wdata_o; we_s = data_we_o;
        if (req_n == ack_at) begin
          data_ack_i   = 1'b1;
          data_rdata_i = rd;
        end
      end else if (!lsu_stall_req_o) begin
        done_s = 1'b1;
        err_s  = lsu_err_o;
        dout_s = lsu_data_o;
      end
      @(posedge clk_i); #1;
      data_ack_i   = 1'b0;
      data_rdata_i = '0;
    end
    lsu_req_i = 1'b0;
    check("access_completes", {31'd0, done_s}, 32'd1);
  endtask

  initial begin
    #2;
    check("rst_data_req", {31'd0, data_req_o}, 32'd0);
    check("rst_err", {31'd0, lsu_err_o}, 32'd0);
    check("rst_data_o", lsu_data_o, 32'd0);
    check("rst_be", {28'd0, data_be_o}, 32'd0);
    check("rst_stall", {31'd0, lsu_stall_req_o}, 32'd0);
    @(posedge clk_i); #1;
    arstn_i = 1'b1;
    @(posedge clk_i); #1;

    // LB 0x103, ack in first BUSY cycle
    do_access(1'b0, 3'd0, 32'h103, 32'h0, 1, 32'h80FF_0000);
    check("lb_be", {28'd0, be_s}, 32'h8);
    check("lb_addr", addr_s, 32'h100);
    check("lb_data", dout_s, 32'hFFFF_FF80);
    check("lb_stall", stall_n, 2);
    check("lb_req", req_n, 1);
    check("lb_err", {31'd0, err_s}, 32'd0);
    #1;
    check("lb_idle_err", {31'd0, lsu_err_o}, 32'd0);

    // SH 0x202, ack in third BUSY cycle
    do_access(1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 3, 32'hFFFF_FFFF);
    check("sh_be", {28'd0, be_s}, 32'hC);
    check("sh_wdata", wdata_s, 32'hABCD_ABCD);
    check("sh_we", {31'd0, we_s}, 32'd1);
    check("sh_addr", addr_s, 32'h200);
    check("sh_stall", stall_n, 4);
    check("sh_err", {31'd0, err_s}, 32'd0);
    check("sh_data", dout_s, 32'd0);

    // Illegal: LHU misaligned, SW misaligned
    do_access(1'b0, 3'd5, 32'h301, 32'h0, 1, 32'h0);
    check("lhu_req", req_n, 0);
    check("lhu_err", {31'd0, err_s}, 32'd1);
    check("lhu_stall", stall_n, 1);
    do_access(1'b1, 3'd2, 32'h302, 32'h5555_AAAA, 1, 32'h0);
    check("sw_req", req_n, 0);
    check("sw_err", {31'd0, err_s}, 32'd1);
    check("sw_stall", stall_n, 1);
    #1;
    check("sw_err_one_cycle", {31'd0, lsu_err_o}, 32'd0);

    // Store with unsigned size is illegal
    do_access(1'b1, 3'd4, 32'h10, 32'h0, 1, 32'h0);
    check("sbu_req", req_n, 0);
    check("sbu_err", {31'd0, err_s}, 32'd1);

    // LW timeout, MAX_WAIT=4
    do_access(1'b0, 3'd2, 32'h400, 32'h0, 0, 32'h0);
    check("to_req", req_n, 4);
    check("to_err", {31'd0, err_s}, 32'd1);
    check("to_data", dout_s, 32'd0);
    check("to_stall", stall_n, 5);

    // Reset during BUSY, ack one cycle after release
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h500;
    @(posedge clk_i); #1;
    check("mid_busy_req", {31'd0, data_req_o}, 32'd1);
    arstn_i = 1'b0;
    lsu_req_i = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, data_req_o}, 32'd0);
    check("mid_rst_addr", data_addr_o, 32'd0);
    check("mid_rst_be", {28'd0, data_be_o}, 32'd0);
    @(posedge clk_i); #1;
    arstn_i = 1'b1;
    @(posedge clk_i); #1;
    data_ack_i = 1'b1; data_rdata_i = 32'hCAFE_F00D;
    @(posedge clk_i); #1;
    data_ack_i = 1'b0; data_rdata_i = '0;
    check("post_rst_req", {31'd0, data_req_o}, 32'd0);
    check("post_rst_err", {31'd0, lsu_err_o}, 32'd0);
    check("post_rst_data", lsu_data_o, 32'd0);
    @(posedge clk_i); #1;
    check("post_rst_data2", lsu_data_o, 32'd0);

    // Back-to-back LW 0x0 / LBU 0x5
    do_access(1'b0, 3'd2, 32'h0, 32'h0, 1, 32'hDEAD_BEEF);
    check("lw_req", req_n, 1);
    check("lw_data", dout_s, 32'hDEAD_BEEF);
    check("lw_be", {28'd0, be_s}, 32'hF);
    do_access(1'b0, 3'd4, 32'h5, 32'h0, 1, 32'h1122_8344);
    check("lbu_req", req_n, 1);
    check("lbu_data", dout_s, 32'h0000_0083);
    check("lbu_be", {28'd0, be_s}, 32'h2);
    check("lbu_addr", addr_s, 32'h4);

    // LH sign-extend upper half
    do_access(1'b0, 3'd1, 32'h12, 32'h0, 2, 32'h8001_7FFF);
    check("lh_data", dout_s, 32'hFFFF_8001);
    check("lh_be", {28'd0, be_s}, 32'hC);
    check("lh_stall", stall_n, 3);

    // SB lane replication
    do_access(1'b1, 3'd0, 32'h21, 32'h0000_00A5, 1, 32'h0);
    check("sb_be", {28'd0, be_s}, 32'h2);
    check("sb_wdata", wdata_s, 32'hA5A5_A5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
